// File: rtl/mseq_bank.sv
// Four Galois LFSR keystream generators reseeded from the chaos controller seed bus,
// packed into OUT_WIDTH-bit words. Define MSEQ_BANK_OVR_CNT_EN to add the load-overrun counter.
module mseq_bank #(
    parameter int INPUT_DATA_WIDTH = 288,
    parameter int WARMUP_CYCLES    = 64,
    parameter int OUT_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INPUT_DATA_WIDTH-1:0] MSEQ_din,
    input  logic [3:0]                  MSEQ_din_valid,
    output logic [OUT_WIDTH-1:0]        key_data,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [3:0]                  ch_running
`ifdef MSEQ_BANK_OVR_CNT_EN
    ,
    output logic [7:0]                  load_ovr_cnt
`endif
);

    localparam int          NWORDS = INPUT_DATA_WIDTH / 32;
    localparam int          NIB    = OUT_WIDTH / 4;
    localparam int          NCW    = $clog2(NIB + 1);
    localparam logic [31:0] POLY   = 32'h80200003;
    // Per-channel salt: golden-ratio constant rotated left by 8*i.
    localparam logic [3:0][31:0] SALT = {32'hB99E3779, 32'h79B99E37, 32'h3779B99E, 32'h9E3779B9};

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [3:0][31:0]     lfsr_q, lfsr_d;
    logic [3:0][1:0]      st_q, st_d;
    logic [3:0][7:0]      wcnt_q, wcnt_d;
    logic [OUT_WIDTH-5:0] acc_q, acc_d;
    logic [NCW-1:0]       ncnt_q, ncnt_d;
    logic [OUT_WIDTH-1:0] key_data_q, key_data_d;
    logic                 key_valid_q, key_valid_d;

    logic [31:0]          fold;
    logic [3:0][31:0]     seed, step;
    logic [3:0]           nibble;
    logic [OUT_WIDTH-1:0] acc_full;
    logic                 gen_en;

    always_comb begin
        fold = '0;
        for (int w = 0; w < NWORDS; w++) fold = fold ^ MSEQ_din[w*32 +: 32];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            seed[i]       = (fold ^ SALT[i]) == '0 ? 32'h00000001 : (fold ^ SALT[i]);
            step[i]       = {1'b0, lfsr_q[i][31:1]} ^ (lfsr_q[i][0] ? POLY : 32'h0);
            nibble[i]     = lfsr_q[i][0];
            ch_running[i] = st_q[i] == ST_RUN;
        end
    end

    assign gen_en = (&ch_running) && !(key_valid_q && !key_ready);

    // A load wins over any step; WARMUP steps ignore backpressure.
    always_comb begin
        lfsr_d = lfsr_q;
        st_d   = st_q;
        wcnt_d = wcnt_q;
        for (int i = 0; i < 4; i++) begin
            if (MSEQ_din_valid[i]) begin
                lfsr_d[i] = seed[i];
                st_d[i]   = ST_WARMUP;
                wcnt_d[i] = 8'(WARMUP_CYCLES);
            end else if (st_q[i] == ST_WARMUP) begin
                lfsr_d[i] = step[i];
                wcnt_d[i] = wcnt_q[i] - 8'd1;
                if (wcnt_q[i] == 8'd1) st_d[i] = ST_RUN;
            end else if (st_q[i] == ST_RUN && gen_en) begin
                lfsr_d[i] = step[i];
            end
        end
    end

    assign acc_full = {acc_q, nibble};

    always_comb begin
        acc_d       = acc_q;
        ncnt_d      = ncnt_q;
        key_data_d  = key_data_q;
        key_valid_d = key_valid_q && !key_ready;
        if (gen_en) begin
            acc_d = acc_full[OUT_WIDTH-5:0];
            if (ncnt_q == NCW'(NIB - 1)) begin
                ncnt_d      = '0;
                key_data_d  = acc_full;
                key_valid_d = 1'b1;
            end else begin
                ncnt_d = ncnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= '0;
            st_q        <= {4{ST_EMPTY}};
            wcnt_q      <= '0;
            acc_q       <= '0;
            ncnt_q      <= '0;
            key_data_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            st_q        <= st_d;
            wcnt_q      <= wcnt_d;
            acc_q       <= acc_d;
            ncnt_q      <= ncnt_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;

`ifdef MSEQ_BANK_OVR_CNT_EN
    // Overrun: a seed lands on a channel still warming up on the previous one.
    logic [3:0] ovr_hits;
    logic [8:0] ovr_sum;
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        for (int i = 0; i < 4; i++) ovr_hits[i] = MSEQ_din_valid[i] && (st_q[i] == ST_WARMUP);
        ovr_sum = {1'b0, ovr_q} + 9'(ovr_hits[0]) + 9'(ovr_hits[1]) + 9'(ovr_hits[2]) + 9'(ovr_hits[3]);
        ovr_d   = ovr_sum > 9'd255 ? 8'hFF : ovr_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= '0;
        else        ovr_q <= ovr_d;
    end

    assign load_ovr_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_mseq_bank.sv
// Bench for mseq_bank: seed-derivation vector table, directed multi-cycle scenarios and
// randomized traffic, all compared every cycle against a queue-based behavioural model.
module tb_mseq_bank;
    localparam int IW  = 288;
    localparam int W   = 64;
    localparam int OW  = 32;
    localparam int NIB = OW / 4;
    localparam logic [31:0] GOLD = 32'h9E3779B9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] din, din_z;
    logic [3:0]    vld, vld_z;
    logic          key_ready;
    logic [OW-1:0] key_data, kd_z;
    logic          key_valid, kv_z;
    logic [3:0]    ch_running, run_z;
`ifdef MSEQ_BANK_OVR_CNT_EN
    logic [7:0]    ovr, ovr_z;
`endif

    mseq_bank #(.INPUT_DATA_WIDTH(IW), .WARMUP_CYCLES(W), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .MSEQ_din(din), .MSEQ_din_valid(vld),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .ch_running(ch_running)
`ifdef MSEQ_BANK_OVR_CNT_EN
        , .load_ovr_cnt(ovr)
`endif
    );

    mseq_bank #(.INPUT_DATA_WIDTH(IW), .WARMUP_CYCLES(1), .OUT_WIDTH(OW)) dut_z (
        .clk(clk), .rst_n(rst_n), .MSEQ_din(din_z), .MSEQ_din_valid(vld_z),
        .key_data(kd_z), .key_valid(kv_z), .key_ready(1'b1),
        .ch_running(run_z)
`ifdef MSEQ_BANK_OVR_CNT_EN
        , .load_ovr_cnt(ovr_z)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [31:0] seed_of(input logic [IW-1:0] d, input int ch);
        logic [31:0] f, salt, s;
        f = '0;
        for (int w = 0; w < IW / 32; w++) f ^= d[w*32 +: 32];
        salt = (ch == 0) ? GOLD : ((GOLD << (8 * ch)) | (GOLD >> (32 - 8 * ch)));
        s = f ^ salt;
        return (s == 0) ? 32'h1 : s;
    endfunction

    // ---------------- behavioural model (main dut) ----------------
    // mode: 0 empty, 1 warming up, 2 running
    logic [31:0] m_s[4];
    int          m_mode[4];
    int          m_wc[4];
    logic [3:0]  m_nq[$];
    logic        m_kv;
    logic [31:0] m_kd;
    int          m_ovr;

    always @(posedge clk or negedge rst_n) begin
        logic g, nw;
        logic [31:0] w;
        int hits;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_s[i] = '0; m_mode[i] = 0; m_wc[i] = 0;
            end
            m_nq.delete();
            m_kv = 1'b0; m_kd = '0; m_ovr = 0;
        end else begin
            g = (m_mode[0] == 2 && m_mode[1] == 2 && m_mode[2] == 2 && m_mode[3] == 2)
                && !(m_kv && !key_ready);
            nw = 1'b0;
            if (g) begin
                m_nq.push_back({m_s[3][0], m_s[2][0], m_s[1][0], m_s[0][0]});
                if (m_nq.size() == NIB) begin
                    w = '0;
                    foreach (m_nq[k]) w = (w << 4) | 32'(m_nq[k]);
                    m_kd = w; nw = 1'b1;
                    m_nq.delete();
                end
            end
            if (nw) m_kv = 1'b1;
            else if (m_kv && key_ready) m_kv = 1'b0;
            hits = 0;
            for (int i = 0; i < 4; i++) begin
                if (vld[i]) begin
                    if (m_mode[i] == 1) hits++;
                    m_s[i] = seed_of(din, i); m_mode[i] = 1; m_wc[i] = W;
                end else if (m_mode[i] == 1) begin
                    m_s[i] = gstep(m_s[i]);
                    m_wc[i]--;
                    if (m_wc[i] == 0) m_mode[i] = 2;
                end else if (m_mode[i] == 2 && g) begin
                    m_s[i] = gstep(m_s[i]);
                end
            end
            m_ovr = (m_ovr + hits > 255) ? 255 : m_ovr + hits;
        end
    end

    function automatic logic [3:0] m_run();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_mode[i] == 2);
        return r;
    endfunction

    task automatic check_cycle();
        chk("cycle", {ch_running, key_valid, key_data, dut.lfsr_q},
            {m_run(), m_kv, m_kd, m_s[3], m_s[2], m_s[1], m_s[0]});
`ifdef MSEQ_BANK_OVR_CNT_EN
        chk("ovr_cnt", ovr, 8'(m_ovr));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_kv(input string nm, input int budget);
        int k = 0;
        while (!key_valid && k < budget) begin
            cyc();
            k++;
        end
        chk(nm, key_valid, 1'b1);
    endtask

    function automatic logic [IW-1:0] rand_din();
        logic [IW-1:0] d;
        for (int w = 0; w < IW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    typedef struct {
        int          widx;
        logic [31:0] word;
        int          ch;
        logic [31:0] exp_seed;
    } seed_vec_t;

    seed_vec_t sv[6];

    initial begin
        int seen;
        logic [31:0] held;
        sv[0] = '{0, 32'h9E3779B9, 0, 32'h00000001};
        sv[1] = '{0, 32'h00000000, 1, 32'h3779B99E};
        sv[2] = '{4, 32'hFFFFFFFF, 1, 32'hC8864661};
        sv[3] = '{8, 32'h12345678, 2, 32'h6B8DC84F};
        sv[4] = '{3, 32'h0F0F0F0F, 3, 32'hB6913876};
        sv[5] = '{2, 32'h3779B99E, 1, 32'h00000001};

        din = '0; vld = '0; din_z = '0; vld_z = '0; key_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_key_data", key_data, '0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_ch_running", ch_running, 4'h0);
        chk("rst_lfsr", dut.lfsr_q, '0);
`ifdef MSEQ_BANK_OVR_CNT_EN
        chk("rst_ovr", ovr, 8'h0);
`endif
        rst_n = 1'b1;

        // Seed derivation incl. zero-seed substitution (WARMUP_CYCLES=1 instance)
        for (int k = 0; k < 6; k++) begin
            din_z = '0;
            din_z[sv[k].widx*32 +: 32] = sv[k].word;
            vld_z = 4'(1 << sv[k].ch);
            cyc();
            chk("seed_load", dut_z.lfsr_q[sv[k].ch], sv[k].exp_seed);
            vld_z = '0;
            cyc();
            chk("seed_step", dut_z.lfsr_q[sv[k].ch], gstep(sv[k].exp_seed));
            chk("seed_running", run_z[sv[k].ch], 1'b1);
            if (k == 0) chk("zero_seed_running", run_z, 4'b0001);
        end

        // First word latency
        din = rand_din(); vld = 4'hF;
        cyc();
        vld = '0;
        repeat (W - 1) cyc();
        chk("warm_not_all_running", ch_running == 4'hF, 1'b0);
        cyc();
        chk("running_at_W", ch_running, 4'hF);
        repeat (NIB - 1) cyc();
        chk("kv_before_first", key_valid, 1'b0);
        cyc();
        chk("kv_first", key_valid, 1'b1);
        chk("first_word", key_data, m_kd);

        // Backpressure
        key_ready = 1'b0;
        held = m_kd;
        repeat (20) cyc();
        chk("bp_hold", key_data, held);
        key_ready = 1'b1;
        repeat (40) cyc();
        repeat (150) begin
            key_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        key_ready = 1'b1;

        // Async reset while a word is held
        wait_kv("pre_reset_kv", 3 * NIB);
        key_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {key_valid, key_data, ch_running}, '0);
        chk("async_rst_lfsr", dut.lfsr_q, '0);
        @(negedge clk);
        rst_n = 1'b1; key_ready = 1'b1;
        repeat (10) cyc();
        chk("post_rst_idle", {key_valid, ch_running}, '0);

        // Staggered loads at 2-cycle spacing
        for (int c = 0; c < 4; c++) begin
            din = rand_din(); vld = 4'(1 << c);
            cyc();
            vld = '0;
            if (c < 3) cyc();
        end
        seen = 0;
        repeat (W - 1) begin
            cyc();
            if (key_valid) seen++;
        end
        chk("stagger_no_early_kv", seen, 0);
        cyc();
        chk("stagger_running", ch_running, 4'hF);
        wait_kv("stagger_kv", NIB + 2);
        chk("stagger_word", key_data, m_kd);

        // Reseed ch2 mid-word, then overrun it while still warming up
        repeat (2) cyc();
        din = rand_din(); vld = 4'b0100;
        cyc();
        vld = '0;
        chk("reseed_paused", ch_running, 4'b1011);
        repeat (4) cyc();
        din = rand_din(); vld = 4'b0100;
        cyc();
        vld = '0;
`ifdef MSEQ_BANK_OVR_CNT_EN
        chk("ovr_one", ovr, 8'd1);
`endif
        repeat (W - 1) cyc();
        chk("reseed_not_running", ch_running, 4'b1011);
        cyc();
        chk("reseed_running", ch_running, 4'hF);
        repeat (NIB - 4) cyc();
        chk("reseed_kv_wait", key_valid, 1'b0);
        cyc();
        chk("reseed_kv", key_valid, 1'b1);
        chk("reseed_word", key_data, m_kd);

        // Random loads and backpressure
        repeat (400) begin
            din = rand_din();
            vld = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
            key_ready = 1'($urandom_range(0, 3) != 0);
            cyc();
        end
        vld = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mseq_bank.md
# mseq_bank

Bank of four 32-bit maximal-length LFSR (M-sequence) generators that consumes the `MSEQ_din` / `MSEQ_din_valid` seed stream produced by the chaos-driven M-sequence controller. Each one-hot valid bit reseeds one generator. The bank runs a warm-up phase, then clocks all four generators in lockstep. Their output bits are packed into `OUT_WIDTH`-bit keystream words on a valid/ready interface, which feeds the downstream encryption datapath.

## Interface
- `INPUT_DATA_WIDTH`, 288: seed bus width; must be a multiple of 32.
- `WARMUP_CYCLES`, 64: discard steps after each reseed; range 1..255.
- `OUT_WIDTH`, 32: keystream word width; must be a multiple of 4 and at least 8.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `MSEQ_din`  in  INPUT_DATA_WIDTH  seed material
- `MSEQ_din_valid`  in  4  one-hot per-channel load strobe; bit i loads channel i
- `key_data`  out  OUT_WIDTH  packed keystream word
- `key_valid`  out  1  `key_data` is valid
- `key_ready`  in  1  consumer accepts the word
- `ch_running`  out  4  channel i is in RUN
- `load_ovr_cnt`  out  8  only when `MSEQ_BANK_OVR_CNT_EN` is defined

## Operation
- **Seed derivation**
  - fold = XOR of all 32-bit words of `MSEQ_din`.
  - seed_i = fold ^ rotl(32'h9E3779B9, 8*i).
  - If seed_i == 0, load 32'h00000001 instead.
- **LFSR step (Galois)**
  - out bit b_i = s[0].
  - s <= (s >> 1) ^ (s[0] ? 32'h80200003 : 0), i.e. polynomial x^32+x^22+x^2+x+1.
- **Per-channel FSM states:** EMPTY, WARMUP, RUN.
  - EMPTY: entered at reset. A load moves the channel to WARMUP with wcnt = WARMUP_CYCLES.
  - WARMUP: the LFSR steps every cycle regardless of `key_ready`; wcnt decrements. When wcnt reaches 1 and the channel steps, it moves to RUN.
  - RUN: the LFSR steps only when gen_en is high.
  - A load in any state reloads the seed and re-enters WARMUP with a full wcnt. A load takes priority over the step in that cycle.
  - Multiple valid bits set in one cycle load each addressed channel with its own salted seed.
- **Generation**
  - gen_en = (&ch_running) && !(key_valid && !key_ready).
  - On gen_en: nibble = {b3,b2,b1,b0}; acc <= {acc[OUT_WIDTH-5:0], nibble}; ncnt increments.
  - On the OUT_WIDTH/4-th nibble: key_data <= {acc[OUT_WIDTH-5:0], nibble}, key_valid <= 1, ncnt <= 0.
- **Handshake**
  - A word transfers when key_valid && key_ready.
  - key_valid falls after a transfer unless a new word completes in the same cycle; in that case key_valid stays 1 and key_data updates.
  - key_data holds stable while key_valid && !key_ready.
- **Reseed while running**
  - gen_en drops until all channels are back in RUN.
  - The partial acc and ncnt are retained. A held `key_data` word is unaffected.

## Timing
- **Reset values:** key_data = 0, key_valid = 0, ch_running = 0, load_ovr_cnt = 0. All LFSRs are 0 (channels EMPTY), acc = 0, ncnt = 0.
- **Load:** a load sampled at edge T0 sets s = seed_i at T0.
  - The first warm-up step is at T0+1.
  - ch_running[i] rises at edge T0+WARMUP_CYCLES.
- **First word:** once the last channel enters RUN at edge TR, generation steps occur at TR+1 … TR+OUT_WIDTH/4.
  - key_valid is visible after edge TR+OUT_WIDTH/4, assuming no stall.
- **Throughput:** one nibble per cycle with key_ready held high, i.e. one word every OUT_WIDTH/4 cycles.
- **Reset mid-operation:** asynchronous. All state returns to reset values immediately, and the in-flight word is lost.

## Configuration
- `MSEQ_BANK_OVR_CNT_EN` defined:
  - Adds port `load_ovr_cnt`, a saturating 8-bit count of loads that hit a channel already in WARMUP (seed arriving before the previous one was used).
  - The count saturates at 255 and clears only on reset.
  - Simultaneous overruns on k channels add k, clamped at 255.
- Not defined: the port and its counter are absent. Behaviour is otherwise identical.

## Test plan
- **Zero-seed substitution.** Stimulus: WARMUP_CYCLES=1; `MSEQ_din` = 32'h9E3779B9 in the low word, zeros elsewhere; valid = 4'b0001. Required: ch0 LFSR = 32'h00000001 at the load edge and 32'h80200003 one cycle later; ch_running = 4'b0001 at that edge.
- **First word latency.** Stimulus: load all four channels in one cycle (valid = 4'b1111), random din, key_ready = 1. Required: ch_running = 4'hF exactly WARMUP_CYCLES edges after the load; key_valid rises 8 edges later (OUT_WIDTH=32); key_data matches the bit-accurate reference model.
- **Backpressure.** Stimulus: key_ready = 0 for 20 cycles after key_valid rises. Required: key_data stable, all LFSRs frozen, no word dropped or duplicated once ready returns. Stream after release matches the model.
- **Staggered loads.** Stimulus: drive valid 0001, 0010, 0100, 1000 at 2-cycle spacing. Required: no key_valid until ch3 completes warm-up; first word matches the model.
- **Reseed in RUN and overrun.** Stimulus: reload ch2 mid-word after 3 nibbles, then reload ch2 again 5 cycles later. Required: generation pauses; the 3 buffered nibbles are kept and the word completes correctly after ch2 re-enters RUN; with the macro defined, load_ovr_cnt = 1.
- **Async reset mid-stream.** Stimulus: assert rst_n low while key_valid = 1. Required: all outputs read 0 immediately; after release, no output until new loads arrive.
